// File: rtl/knight_pkg.sv
// Shared knight-move definitions: headings, one-hot move codes and the
// move-to-legs split used by the tour solver and its consumers.
package knight_pkg;

  typedef enum logic [1:0] {
    HEAD_N = 2'b00,
    HEAD_E = 2'b01,
    HEAD_S = 2'b10,
    HEAD_W = 2'b11
  } heading_t;

  localparam logic [7:0] MOVE_B0 = 8'b0000_0001;
  localparam logic [7:0] MOVE_B1 = 8'b0000_0010;
  localparam logic [7:0] MOVE_B2 = 8'b0000_0100;
  localparam logic [7:0] MOVE_B3 = 8'b0000_1000;
  localparam logic [7:0] MOVE_B4 = 8'b0001_0000;
  localparam logic [7:0] MOVE_B5 = 8'b0010_0000;
  localparam logic [7:0] MOVE_B6 = 8'b0100_0000;
  localparam logic [7:0] MOVE_B7 = 8'b1000_0000;

  typedef struct packed {
    heading_t   heading;
    logic [1:0] squares;
  } leg_t;

  typedef struct packed {
    leg_t y_leg;
    leg_t x_leg;
    logic legal;
  } move_legs_t;

  function automatic leg_t make_leg(input heading_t heading, input logic [1:0] squares);
    leg_t leg;
    leg.heading = heading;
    leg.squares = squares;
    return leg;
  endfunction

  // Zero or multi-hot codes fall to the default arm and come back illegal.
  function automatic move_legs_t move_to_legs(input logic [7:0] move);
    move_legs_t legs;
    legs.legal = 1'b1;
    case (move)
      MOVE_B0: begin legs.y_leg = make_leg(HEAD_N, 2'd2); legs.x_leg = make_leg(HEAD_E, 2'd1); end
      MOVE_B1: begin legs.y_leg = make_leg(HEAD_N, 2'd2); legs.x_leg = make_leg(HEAD_W, 2'd1); end
      MOVE_B2: begin legs.y_leg = make_leg(HEAD_N, 2'd1); legs.x_leg = make_leg(HEAD_W, 2'd2); end
      MOVE_B3: begin legs.y_leg = make_leg(HEAD_S, 2'd1); legs.x_leg = make_leg(HEAD_W, 2'd2); end
      MOVE_B4: begin legs.y_leg = make_leg(HEAD_S, 2'd2); legs.x_leg = make_leg(HEAD_W, 2'd1); end
      MOVE_B5: begin legs.y_leg = make_leg(HEAD_S, 2'd2); legs.x_leg = make_leg(HEAD_E, 2'd1); end
      MOVE_B6: begin legs.y_leg = make_leg(HEAD_S, 2'd1); legs.x_leg = make_leg(HEAD_E, 2'd2); end
      MOVE_B7: begin legs.y_leg = make_leg(HEAD_N, 2'd1); legs.x_leg = make_leg(HEAD_E, 2'd2); end
      default: begin
        legs.y_leg = make_leg(HEAD_N, 2'd1);
        legs.x_leg = make_leg(HEAD_E, 2'd1);
        legs.legal = 1'b0;
      end
    endcase
    return legs;
  endfunction

endpackage

// File: rtl/move_leg_decoder.sv
// Combinational split of a one-hot knight move into its Y and X legs,
// with a flag for codes that are not exactly one-hot.
module move_leg_decoder
  import knight_pkg::*;
(
  input  logic [7:0] move,
  output leg_t       y_leg,
  output leg_t       x_leg,
  output logic       legal
);

  move_legs_t legs_s;

  // Decode the move code into both legs
  always_comb begin
    legs_s = move_to_legs(move);
  end

  assign y_leg = legs_s.y_leg;
  assign x_leg = legs_s.x_leg;
  assign legal = legs_s.legal;

endmodule

// File: rtl/tour_move_sequencer.sv
// Replays a solved knight's tour: reads each move from the solver and issues
// its Y then X leg to the motion controller, waiting for each leg to finish.
module tour_move_sequencer
  import knight_pkg::*;
#(
  parameter  int BOARD_SIZE = 5,
  localparam int NUM_MOVES  = BOARD_SIZE * BOARD_SIZE - 1,
  localparam int INDX_W     = $clog2(NUM_MOVES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [INDX_W-1:0] indx,
  input  logic [7:0]        move,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_heading,
  output logic [1:0]        cmd_squares,
  output logic              cmd_last_leg,
  input  logic              leg_done,
  output logic              busy,
  output logic              tour_done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SEND_Y = 3'd2,
    ST_WAIT_Y = 3'd3,
    ST_SEND_X = 3'd4,
    ST_WAIT_X = 3'd5
  } state_t;

  localparam logic [INDX_W-1:0] LAST_INDX = INDX_W'(NUM_MOVES - 1);

  state_t            state_r, state_s;
  logic [INDX_W-1:0] indx_r, indx_s;
  logic [7:0]        move_q_r, move_q_s;
  logic              cmd_valid_r, cmd_valid_s;
  heading_t          heading_r, heading_s;
  logic [1:0]        squares_r, squares_s;
  logic              last_leg_r, last_leg_s;
  logic              busy_r, busy_s;
  logic              tour_done_r, tour_done_s;
  logic              err_r, err_s;

  logic [7:0] dec_move_s;
  leg_t       dec_y_s;
  leg_t       dec_x_s;
  logic       dec_legal_s;

  // The live solver output is decoded in FETCH; later the captured move is.
  assign dec_move_s = (state_r == ST_FETCH) ? move : move_q_r;

  move_leg_decoder u_decoder (
    .move  (dec_move_s),
    .y_leg (dec_y_s),
    .x_leg (dec_x_s),
    .legal (dec_legal_s)
  );

  // Next-state and next registered-output logic
  always_comb begin
    state_s     = state_r;
    indx_s      = indx_r;
    move_q_s    = move_q_r;
    cmd_valid_s = cmd_valid_r;
    heading_s   = heading_r;
    squares_s   = squares_r;
    last_leg_s  = last_leg_r;
    tour_done_s = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          indx_s  = '0;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        move_q_s = move;
        if (dec_legal_s) begin
          state_s     = ST_SEND_Y;
          cmd_valid_s = 1'b1;
          heading_s   = dec_y_s.heading;
          squares_s   = dec_y_s.squares;
          last_leg_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end
      end
      ST_SEND_Y: begin
        if (cmd_ready) begin
          state_s     = ST_WAIT_Y;
          cmd_valid_s = 1'b0;
        end else begin
          state_s = ST_SEND_Y;
        end
      end
      ST_WAIT_Y: begin
        if (leg_done) begin
          state_s     = ST_SEND_X;
          cmd_valid_s = 1'b1;
          heading_s   = dec_x_s.heading;
          squares_s   = dec_x_s.squares;
          last_leg_s  = 1'b1;
        end else begin
          state_s = ST_WAIT_Y;
        end
      end
      ST_SEND_X: begin
        if (cmd_ready) begin
          state_s     = ST_WAIT_X;
          cmd_valid_s = 1'b0;
        end else begin
          state_s = ST_SEND_X;
        end
      end
      ST_WAIT_X: begin
        if (!leg_done) begin
          state_s = ST_WAIT_X;
        end else if (indx_r == LAST_INDX) begin
          state_s     = ST_IDLE;
          tour_done_s = 1'b1;
        end else begin
          state_s = ST_FETCH;
          indx_s  = indx_r + INDX_W'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cmd_valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      indx_r      <= '0;
      move_q_r    <= 8'h00;
      cmd_valid_r <= 1'b0;
      heading_r   <= HEAD_N;
      squares_r   <= 2'd0;
      last_leg_r  <= 1'b0;
      busy_r      <= 1'b0;
      tour_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      indx_r      <= indx_s;
      move_q_r    <= move_q_s;
      cmd_valid_r <= cmd_valid_s;
      heading_r   <= heading_s;
      squares_r   <= squares_s;
      last_leg_r  <= last_leg_s;
      busy_r      <= busy_s;
      tour_done_r <= tour_done_s;
      err_r       <= err_s;
    end
  end

  assign indx         = indx_r;
  assign cmd_valid    = cmd_valid_r;
  assign cmd_heading  = heading_r;
  assign cmd_squares  = squares_r;
  assign cmd_last_leg = last_leg_r;
  assign busy         = busy_r;
  assign tour_done    = tour_done_r;
  assign err          = err_r;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Directed self-checking bench for tour_move_sequencer with a stub solver
// move table and hand-computed leg payloads.
module tb_tour_move_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] indx;
  logic [7:0] move;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [1:0] cmd_heading;
  logic [1:0] cmd_squares;
  logic       cmd_last_leg;
  logic       leg_done = 1'b0;
  logic       busy;
  logic       tour_done;
  logic       err;

  logic [7:0] move_tab [0:31];
  int assert_cnt = 0;
  int fail_cnt = 0;
  int accept_cnt = 0;
  int tour_done_cnt = 0;
  int err_cnt = 0;
  int acc0, td0, err0;

  always #5 clk = ~clk;

  assign move = move_tab[indx];

  tour_move_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .indx         (indx),
    .move         (move),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_heading  (cmd_heading),
    .cmd_squares  (cmd_squares),
    .cmd_last_leg (cmd_last_leg),
    .leg_done     (leg_done),
    .busy         (busy),
    .tour_done    (tour_done),
    .err          (err)
  );

  // Event counters sampled on the active edge
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) accept_cnt <= accept_cnt + 1;
    if (tour_done) tour_done_cnt <= tour_done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {y_heading, y_squares, x_heading, x_squares} for move bit b
  function automatic logic [7:0] exp_leg(input int b);
    case (b)
      0: return {2'd0, 2'd2, 2'd1, 2'd1};
      1: return {2'd0, 2'd2, 2'd3, 2'd1};
      2: return {2'd0, 2'd1, 2'd3, 2'd2};
      3: return {2'd2, 2'd1, 2'd3, 2'd2};
      4: return {2'd2, 2'd2, 2'd3, 2'd1};
      5: return {2'd2, 2'd2, 2'd1, 2'd1};
      6: return {2'd2, 2'd1, 2'd1, 2'd2};
      default: return {2'd0, 2'd1, 2'd1, 2'd2};
    endcase
  endfunction

  task automatic fill_cycle();
    for (int i = 0; i < 32; i++) move_tab[i] = 8'd1 << (i % 8);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accept one leg (ready high) and optionally finish it 3 cycles later.
  task automatic serve_leg(input logic [1:0] hd, input logic [1:0] sq, input logic last,
                           input int idx, input bit done);
    int t;
    t = 0;
    cmd_ready = 1'b1;
    while (!cmd_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("leg_valid", cmd_valid, 32'd1);
    check_eq("leg_heading", cmd_heading, hd);
    check_eq("leg_squares", cmd_squares, sq);
    check_eq("leg_last", cmd_last_leg, last);
    check_eq("leg_indx", indx, idx);
    @(negedge clk);
    if (done) begin
      repeat (2) @(negedge clk);
      leg_done = 1'b1;
      @(negedge clk);
      leg_done = 1'b0;
    end
  endtask

  task automatic serve_move(input int b, input int idx, input bit done_x);
    logic [7:0] e;
    e = exp_leg(b);
    serve_leg(e[7:6], e[5:4], 1'b0, idx, 1'b1);
    serve_leg(e[3:2], e[1:0], 1'b1, idx, done_x);
  endtask

  initial begin
    fill_cycle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_valid", cmd_valid, 32'd0);
    check_eq("rst_indx", indx, 32'd0);
    check_eq("rst_tour_done", tour_done, 32'd0);
    check_eq("rst_err", err, 32'd0);
    check_eq("rst_payload", {cmd_heading, cmd_squares, cmd_last_leg}, 32'd0);

    // Single move b0 with exact latencies
    pulse_start();
    check_eq("lat_start_1", cmd_valid, 32'd0);
    @(negedge clk);
    check_eq("lat_start_2", cmd_valid, 32'd1);
    check_eq("b0_y", {cmd_heading, cmd_squares, cmd_last_leg}, {2'd0, 2'd2, 1'b0});
    check_eq("b0_busy", busy, 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_eq("b0_y_acc", cmd_valid, 32'd0);
    leg_done = 1'b1;
    @(negedge clk);
    leg_done = 1'b0;
    check_eq("b0_x_lat", cmd_valid, 32'd1);
    check_eq("b0_x", {cmd_heading, cmd_squares, cmd_last_leg}, {2'd1, 2'd1, 1'b1});
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_eq("b0_x_acc", cmd_valid, 32'd0);
    leg_done = 1'b1;
    @(negedge clk);
    leg_done = 1'b0;
    check_eq("b0_next_indx", indx, 32'd1);
    check_eq("b0_fetch_valid", cmd_valid, 32'd0);
    @(negedge clk);
    check_eq("b1_y_lat", cmd_valid, 32'd1);
    check_eq("b1_y", {cmd_heading, cmd_squares}, {2'd0, 2'd2});
    reset_dut();

    // Backpressure on a Y leg
    acc0 = accept_cnt;
    move_tab[0] = 8'h08;
    pulse_start();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", cmd_valid, 32'd1);
      check_eq("bp_payload", {cmd_heading, cmd_squares, cmd_last_leg}, {2'd2, 2'd1, 1'b0});
      @(negedge clk);
    end
    check_eq("bp_no_accept", accept_cnt - acc0, 32'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_eq("bp_accepted", cmd_valid, 32'd0);
    check_eq("bp_accept_cnt", accept_cnt - acc0, 32'd1);
    reset_dut();
    fill_cycle();

    // Illegal move encodings at indx 3
    for (int k = 0; k < 2; k++) begin
      move_tab[3] = (k == 0) ? 8'h00 : 8'h11;
      acc0 = accept_cnt;
      err0 = err_cnt;
      pulse_start();
      for (int i = 0; i < 3; i++) serve_move(i, i, 1'b1);
      cmd_ready = 1'b0;
      check_eq("ill_fetch_indx", indx, 32'd3);
      check_eq("ill_err_early", err, 32'd0);
      @(negedge clk);
      check_eq("ill_err", err, 32'd1);
      check_eq("ill_busy", busy, 32'd0);
      check_eq("ill_valid", cmd_valid, 32'd0);
      @(negedge clk);
      check_eq("ill_err_pulse", err, 32'd0);
      check_eq("ill_idle_valid", cmd_valid, 32'd0);
      check_eq("ill_accepts", accept_cnt - acc0, 32'd6);
      check_eq("ill_err_cnt", err_cnt - err0, 32'd1);
    end
    fill_cycle();

    // Spurious leg_done and start pulses
    acc0 = accept_cnt;
    cmd_ready = 1'b0;
    leg_done = 1'b1;
    @(negedge clk);
    leg_done = 1'b0;
    check_eq("sp_idle_busy", busy, 32'd0);
    check_eq("sp_idle_valid", cmd_valid, 32'd0);
    pulse_start();
    leg_done = 1'b1;
    @(negedge clk);
    check_eq("sp_fetch_valid", cmd_valid, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("sp_sendy_valid", cmd_valid, 32'd1);
    check_eq("sp_sendy_indx", indx, 32'd0);
    check_eq("sp_sendy_payload", {cmd_heading, cmd_squares, cmd_last_leg}, {2'd0, 2'd2, 1'b0});
    cmd_ready = 1'b1;
    @(negedge clk);
    leg_done = 1'b0;
    cmd_ready = 1'b0;
    check_eq("sp_waity_valid", cmd_valid, 32'd0);
    @(negedge clk);
    check_eq("sp_acc_leg_done", cmd_valid, 32'd0);
    check_eq("sp_accepts", accept_cnt - acc0, 32'd1);
    leg_done = 1'b1;
    @(negedge clk);
    leg_done = 1'b0;
    check_eq("sp_x_valid", cmd_valid, 32'd1);
    check_eq("sp_x_payload", {cmd_heading, cmd_squares, cmd_last_leg}, {2'd1, 2'd1, 1'b1});
    reset_dut();

    // Full 24-move tour
    acc0 = accept_cnt;
    td0 = tour_done_cnt;
    pulse_start();
    for (int i = 0; i < 24; i++) serve_move(i % 8, i, 1'b1);
    check_eq("tour_done_pulse", tour_done, 32'd1);
    check_eq("tour_busy", busy, 32'd0);
    check_eq("tour_valid", cmd_valid, 32'd0);
    @(negedge clk);
    check_eq("tour_done_clear", tour_done, 32'd0);
    check_eq("tour_accepts", accept_cnt - acc0, 32'd48);
    check_eq("tour_done_cnt", tour_done_cnt - td0, 32'd1);

    // Reset during WAIT_X of indx 10
    td0 = tour_done_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) serve_move(i % 8, i, 1'b1);
    serve_move(2, 10, 1'b0);
    cmd_ready = 1'b0;
    reset_dut();
    check_eq("mid_rst_busy", busy, 32'd0);
    check_eq("mid_rst_valid", cmd_valid, 32'd0);
    check_eq("mid_rst_indx", indx, 32'd0);
    leg_done = 1'b1;
    @(negedge clk);
    leg_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_no_done", tour_done_cnt - td0, 32'd0);
    check_eq("mid_rst_idle", busy, 32'd0);
    pulse_start();
    serve_move(0, 0, 1'b1);
    check_eq("replay_next_indx", indx, 32'd1);
    reset_dut();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
